// File: rtl/inst_prefetch_queue_if.sv
// Bundle of imem request/response, redirect and dequeue signals around the prefetch queue.
// The master modport is the queue itself; slave is the imem/fetch side.
interface inst_prefetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          imem_read;
  logic [31:0]   imem_address;
  logic          imem_resp;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          deq_ready;
  logic          deq_valid;
  logic [31:0]   deq_pc;
  logic [31:0]   deq_instr;
  logic [CW-1:0] count;

  modport master (
    output imem_read, imem_address, deq_valid, deq_pc, deq_instr, count,
    input  imem_resp, imem_rdata, redirect, redirect_pc, deq_ready
  );

  modport slave (
    input  imem_read, imem_address, deq_valid, deq_pc, deq_instr, count,
    output imem_resp, imem_rdata, redirect, redirect_pc, deq_ready
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential imem reads ahead of fetch and
// buffers {pc, instr} pairs; a redirect flushes the queue and drops stale responses.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input logic                   clk,
  input logic                   rst,
  inst_prefetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, pc_next, req_pc;
  logic [CW-1:0] count, count_next;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          enq, pop, deq_valid, room, load_req;

  assign deq_valid        = (count != '0);
  assign bus.deq_valid    = deq_valid;
  assign bus.deq_pc       = deq_valid ? pc_mem[rd_ptr]    : '0;
  assign bus.deq_instr    = deq_valid ? instr_mem[rd_ptr] : '0;
  assign bus.imem_read    = (state != IDLE);
  assign bus.imem_address = req_pc;
  assign bus.count        = count;

  always_comb begin
    enq        = (state == REQ) && bus.imem_resp && !bus.redirect;
    pop        = deq_valid && bus.deq_ready && !bus.redirect;
    count_next = bus.redirect ? '0 : count + CW'(enq) - CW'(pop);
    if (bus.redirect)
      pc_next = {bus.redirect_pc[31:2], 2'b00};
    else if (enq)
      pc_next = fetch_pc + 32'd4;
    else
      pc_next = fetch_pc;
    // Issuing only when the post-update occupancy leaves a slot guarantees
    // every outstanding request a place in the queue.
    room       = (count_next < CW'(DEPTH));
    state_next = state;
    load_req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (room) begin
          state_next = REQ;
          load_req   = 1'b1;
        end
      end
      REQ, DROP: begin
        if (bus.imem_resp) begin
          if (room) begin
            state_next = REQ;
            load_req   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (bus.redirect) begin
          state_next = DROP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= pc_next;
      count    <= count_next;
      if (load_req)
        req_pc <= pc_next;
      if (bus.redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule
